// File: rtl/buffer_64bit.sv
// Byte-addressable scratch buffer with an aliased little-endian 64-bit word view.
// Optional macro BUFFER_64BIT_WRITE_FIRST_EN forwards same-mode write data to a simultaneous read.
module buffer_64bit #(
  parameter int BuffDepth = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 write_en,
  input  logic                                 read_en,
  input  logic                                 addr_mode,
  input  logic [$clog2(BuffDepth)-1:0]         byte_addr,
  input  logic [$clog2(BuffDepth/8)-1:0]       word_addr,
  input  logic [7:0]                           byte_in,
  input  logic [63:0]                          word_in,
  output logic [7:0]                           byte_out,
  output logic [63:0]                          word_out
);

  localparam int ByteAddrW = $clog2(BuffDepth);
  localparam int WordAddrW = $clog2(BuffDepth / 8);

  logic [7:0]  mem_q [BuffDepth];
  logic [7:0]  mem_d [BuffDepth];
  logic [7:0]  byte_out_q, byte_out_d;
  logic [63:0] word_out_q, word_out_d;
  logic [63:0] rd_word;

  // Word k-lane maps to byte address {word_addr, k}.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++) begin
      rd_word[k*8 +: 8] = mem_q[{word_addr, 3'(k)}];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (write_en) begin
      if (!addr_mode) begin
        mem_d[byte_addr] = byte_in;
      end else begin
        for (int k = 0; k < 8; k++) begin
          mem_d[{word_addr, 3'(k)}] = word_in[k*8 +: 8];
        end
      end
    end
  end

  // Reads sample the pre-write contents unless same-mode forwarding is built in.
  always_comb begin
    byte_out_d = byte_out_q;
    word_out_d = word_out_q;
    if (read_en && !addr_mode) byte_out_d = mem_q[byte_addr];
    if (read_en && addr_mode)  word_out_d = rd_word;
`ifdef BUFFER_64BIT_WRITE_FIRST_EN
    if (read_en && write_en && !addr_mode) byte_out_d = byte_in;
    if (read_en && write_en && addr_mode)  word_out_d = word_in;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BuffDepth; i++) mem_q[i] <= '0;
      byte_out_q <= '0;
      word_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      byte_out_q <= byte_out_d;
      word_out_q <= word_out_d;
    end
  end

  assign byte_out = byte_out_q;
  assign word_out = word_out_q;

  logic unused_widths;
  assign unused_widths = ^{ByteAddrW[0], WordAddrW[0]};

endmodule

// File: tb/tb_buffer_64bit.sv
// Bench for buffer_64bit: directed vector table followed by randomized traffic against a byte-array model.
module tb_buffer_64bit;

  localparam int BD = 256;

  logic        clk = 1'b0;
  logic        rst, write_en, read_en, addr_mode;
  logic [7:0]  byte_addr;
  logic [4:0]  word_addr;
  logic [7:0]  byte_in;
  logic [63:0] word_in;
  logic [7:0]  byte_out;
  logic [63:0] word_out;

  int errors = 0;
  int checks = 0;

  buffer_64bit #(.BuffDepth(BD)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .addr_mode(addr_mode), .byte_addr(byte_addr), .word_addr(word_addr),
    .byte_in(byte_in), .word_in(word_in), .byte_out(byte_out), .word_out(word_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, we, re, md;
    logic [7:0]  ba;
    logic [4:0]  wa;
    logic [7:0]  bi;
    logic [63:0] wi;
    logic [7:0]  eb;
    logic [63:0] ew;
  } vec_t;

  vec_t vq[$];

`ifdef BUFFER_64BIT_WRITE_FIRST_EN
  localparam logic [7:0] SimExp = 8'h3C;
`else
  localparam logic [7:0] SimExp = 8'hFF;
`endif

  function automatic vec_t mk(bit r, bit we, bit re, bit md, int ba, int wa,
                              logic [7:0] bi, logic [63:0] wi, logic [7:0] eb, logic [63:0] ew);
    vec_t v;
    v.r = r; v.we = we; v.re = re; v.md = md;
    v.ba = 8'(ba); v.wa = 5'(wa); v.bi = bi; v.wi = wi; v.eb = eb; v.ew = ew;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(logic r, logic we, logic re, logic md, logic [7:0] ba, logic [4:0] wa,
                       logic [7:0] bi, logic [63:0] wi);
    @(negedge clk);
    rst = r; write_en = we; read_en = re; addr_mode = md;
    byte_addr = ba; word_addr = wa; byte_in = bi; word_in = wi;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [7:0]  mem_m [BD];
  logic [7:0]  eb_m;
  logic [63:0] ew_m;

  function automatic logic [63:0] word_of(int w);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v = v | (64'(mem_m[w*8 + k]) << (8*k));
    return v;
  endfunction

  initial begin
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0; addr_mode = 1'b0;
    byte_addr = '0; word_addr = '0; byte_in = '0; word_in = '0;

    vq.push_back(mk(1,0,0,0,  0,0, 8'h00, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,0,1,0, 23,0, 8'h00, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,1,0,0,  7,0, 8'hFF, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,0,1,0,  7,0, 8'h00, 64'h0, 8'hFF, 64'h0));
    vq.push_back(mk(0,0,1,0,  6,0, 8'h00, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,0,1,0,  8,0, 8'h00, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,1,0,1,  0,2, 8'h00, 64'h0807060504030201, 8'h00, 64'h0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0,0,1,0, 16+i,0, 8'h00, 64'h0, 8'(i+1), 64'h0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0,1,0,0, 248+i,0, 8'(8'hA0+i), 64'h0, 8'h08, 64'h0));
    vq.push_back(mk(0,0,1,1,  0,31, 8'h00, 64'h0, 8'h08, 64'hA7A6A5A4A3A2A1A0));
    vq.push_back(mk(0,0,1,1,  0,2,  8'h00, 64'h0, 8'h08, 64'h0807060504030201));
    vq.push_back(mk(0,1,1,0,  7,0,  8'h3C, 64'h0, SimExp, 64'h0807060504030201));
    vq.push_back(mk(0,0,1,0,  7,0,  8'h00, 64'h0, 8'h3C, 64'h0807060504030201));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0,0,0,i%2,  i,i, 8'h99, 64'h99, 8'h3C, 64'h0807060504030201));
    vq.push_back(mk(1,1,0,0,  9,0,  8'h55, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,0,1,0,  9,0,  8'h00, 64'h0, 8'h00, 64'h0));
    vq.push_back(mk(0,0,1,1,  0,2,  8'h00, 64'h0, 8'h00, 64'h0));

    foreach (vq[i]) begin
      apply(vq[i].r, vq[i].we, vq[i].re, vq[i].md, vq[i].ba, vq[i].wa, vq[i].bi, vq[i].wi);
      check($sformatf("vec%0d_byte_out", i), 64'(byte_out), 64'(vq[i].eb));
      check($sformatf("vec%0d_word_out", i), word_out, vq[i].ew);
    end

    // Randomized traffic, starting from a known reset state
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < BD; i++) mem_m[i] = 8'h00;
    eb_m = 8'h00; ew_m = 64'h0;

    for (int n = 0; n < 600; n++) begin
      logic r, we, re, md;
      logic [7:0] ba, bi;
      logic [4:0] wa;
      logic [63:0] wi;
      r  = ($urandom_range(0, 49) == 0);
      we = $urandom_range(0, 1) == 1;
      re = $urandom_range(0, 2) != 0;
      md = $urandom_range(0, 1) == 1;
      ba = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3))  : 5'($urandom);
      bi = 8'($urandom);
      wi = {$urandom, $urandom};

      if (r) begin
        for (int i = 0; i < BD; i++) mem_m[i] = 8'h00;
        eb_m = 8'h00; ew_m = 64'h0;
      end else begin
        if (re && !md) eb_m = mem_m[int'(ba)];
        if (re && md)  ew_m = word_of(int'(wa));
`ifdef BUFFER_64BIT_WRITE_FIRST_EN
        if (re && we && !md) eb_m = bi;
        if (re && we && md)  ew_m = wi;
`endif
        if (we && !md) mem_m[int'(ba)] = bi;
        if (we && md)
          for (int k = 0; k < 8; k++) mem_m[int'(wa)*8 + k] = wi[8*k +: 8];
      end

      apply(r, we, re, md, ba, wa, bi, wi);
      check($sformatf("rnd%0d_byte_out", n), 64'(byte_out), 64'(eb_m));
      check($sformatf("rnd%0d_word_out", n), word_out, ew_m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buffer_64bit.md
Name: buffer_64bit

Overview:
- Single-port on-chip scratch buffer of BuffDepth bytes with two access views.
  - Byte view: 8-bit access.
  - Word view: 64-bit access, 8 aligned bytes at a time.
- addr_mode selects the view for each access.
- Used as an accelerator operand/result store. Control logic pokes individual bytes; the datapath streams whole 64-bit words.

Parameters:
- BuffDepth, 256, total capacity in bytes. Must be a power of two and >= 8.
- ByteAddrW, $clog2(BuffDepth), derived localparam, byte address width (8 at default).
- WordAddrW, $clog2(BuffDepth/8), derived localparam, word address width (5 at default).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous active-high reset.
- write_en  input  1  write strobe for the current cycle.
- read_en  input  1  read strobe for the current cycle.
- addr_mode  input  1  0 = byte view (byte_addr/byte_in/byte_out); 1 = word view (word_addr/word_in/word_out).
- byte_addr  input  ByteAddrW  byte address, used when addr_mode=0.
- word_addr  input  WordAddrW  word address, used when addr_mode=1.
- byte_in  input  8  byte write data.
- word_in  input  64  word write data.
- byte_out  output  8  registered byte read data.
- word_out  output  64  registered word read data.

Behaviour:
- Storage: BuffDepth bytes, mem[0..BuffDepth-1].
- Word mapping is little-endian. Word w, bits [8k+7:8k] (k=0..7) = mem[8w+k].
- All state updates on the rising clk edge only.
- Reset:
  - rst=1 at an edge clears every mem byte to 0.
  - Same edge clears byte_out=0 and word_out=0.
  - Reset overrides write_en/read_en in that cycle.
  - Reset mid-operation discards any in-flight access.
- Byte write (write_en=1, addr_mode=0): mem[byte_addr] <= byte_in.
- Word write (write_en=1, addr_mode=1): mem[8*word_addr+k] <= word_in[8k+7:8k] for all k.
- Byte read (read_en=1, addr_mode=0):
  - byte_out <= mem[byte_addr].
  - Valid 1 cycle after the strobe edge.
- Word read (read_en=1, addr_mode=1):
  - word_out <= assembled word at word_addr.
  - Valid 1 cycle after the strobe edge.
- Output holding:
  - Each output changes only on a read in its own view.
  - Otherwise it holds its last value, including when read_en=0 or the other view is active.
- Simultaneous read and write in the same cycle: both take effect.
  - Read returns pre-write contents (read-before-write), including on overlapping addresses.
  - Overlap covers byte address inside the addressed word.
- No out-of-range condition: address widths exactly span the buffer, so addresses wrap naturally.
- Byte and word views alias the same storage.
  - A byte write is visible through a later word read, and vice versa.
- No handshake or backpressure. Every strobe is accepted the cycle it is asserted.

Optional Feature:
- Macro: BUFFER_64BIT_WRITE_FIRST_EN.
- Defined: a simultaneous read and write in the same mode returns the new data (write-first forwarding).
  - Same address in byte mode: byte_out <= byte_in.
  - Same address in word mode: word_out <= word_in.
- Not defined: read-before-write as specified above.
- Cross-mode overlap is read-before-write in both builds.

Test Plan:
- Reset: rst=1 one cycle, then byte read addr 23 -> byte_out=8'h00 one cycle later; word_out=64'h0.
- Byte write then read:
  - Write byte 7 = 8'hFF (write_en=1, addr_mode=0).
  - Then read_en at addr 7 -> byte_out=8'hFF one cycle later.
  - Addr 6 and 8 still read 8'h00.
- Word write, byte read: word write addr 2 = 64'h0807060504030201 -> byte reads 16..23 return 01..08 in order.
- Byte writes, word read:
  - Bytes 248..255 written 8'hA0..8'hA7.
  - Word read addr 31 -> word_out=64'hA7A6A5A4A3A2A1A0.
  - byte_out unchanged.
- Simultaneous access:
  - Byte 7 holds 8'hFF; same cycle write 8'h3C and read addr 7.
  - byte_out=8'hFF, or 8'h3C with BUFFER_64BIT_WRITE_FIRST_EN.
  - Next read gives 8'h3C.
- Hold and reset mid-operation:
  - read_en=0 for 3 cycles -> outputs unchanged.
  - rst asserted together with a write to byte 9 = 8'h55 -> byte 9 reads 8'h00 afterwards.
